// File: rtl/mips_pkg.sv
// Shared encodings for the data-memory stage: access sizes, FSM states and
// the alignment rule used when a request is accepted.
package mips_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } dmem_state_t;

  // The reserved size encoding behaves like a word, so it needs word alignment.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return (lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-wide data RAM with per-byte write enables and a registered read port.
// Contents are deliberately not reset so the array maps onto block RAM.
module dmem_ram
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic [3:0]      be_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be_i[i]) begin
        mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/data_mem_unit.sv
// Multi-cycle data-memory stage: latches the ALU address and operands, waits a
// programmable number of cycles, performs one RAM access and pulses done.
module data_mem_unit
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic            we,
  input  logic [1:0]      size,
  input  logic            sign_ext,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata,
  output logic            done,
  output logic            err,
  output logic            stall
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_t     state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic            sx_q, sx_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] ram_rdata, ram_wdata, load_val;
  logic [3:0]      ram_be;
  logic [AW-1:0]   ram_raddr;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  // Address bits above the array wrap away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[XLEN-1:AW+2];

  // In IDLE the read port follows the live address so data is ready by ACCESS
  // even with zero wait states.
  assign ram_raddr = (state_q == IDLE) ? addr[AW+1:2] : addr_q[AW+1:2];

  dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk    (clk),
    .be_i   (ram_be),
    .waddr_i(addr_q[AW+1:2]),
    .wdata_i(ram_wdata),
    .raddr_i(ram_raddr),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    ram_be    = 4'b0000;
    ram_wdata = wdata_q;
    case (size_q)
      SZ_BYTE: begin
        ram_be    = 4'b0001 << addr_q[1:0];
        ram_wdata = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        ram_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{wdata_q[15:0]}};
      end
      default: ram_be = 4'b1111;
    endcase
    if (!(state_q == ACCESS && we_q)) begin
      ram_be = 4'b0000;
    end

    ld_byte = ram_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (size_q)
      SZ_BYTE: load_val = {{24{sx_q & ld_byte[7]}}, ld_byte};
      SZ_HALF: load_val = {{16{sx_q & ld_half[15]}}, ld_half};
      default: load_val = ram_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    size_d  = size_q;
    sx_d    = sx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = addr[AW+1:0];
          we_d    = we;
          size_d  = size;
          sx_d    = sign_ext;
          wdata_d = wdata;
          if (is_misaligned(size, addr[1:0])) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (WAIT_STATES == 0) begin
            state_d = ACCESS;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = RESP;
        err_d   = 1'b0;
        rdata_d = we_q ? '0 : load_val;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      sx_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sx_q    <= sx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rdata = rdata_q;
  assign err   = err_q;
  assign done  = (state_q == RESP);
  assign stall = req & ~done;

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: one instance with one wait state and
// one with three, sharing operand inputs but with private req/reset.
module tb_data_mem_unit;

  logic        clk = 1'b0;
  logic        rst_n1, rst_n3;
  logic        req1, req3;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr, wdata;
  logic [31:0] rdata1, rdata3;
  logic        done1, done3, err1, err3, stall1, stall3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  data_mem_unit #(.DEPTH_WORDS(256), .WAIT_STATES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n1), .req(req1), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata1), .done(done1), .err(err1), .stall(stall1)
  );

  data_mem_unit #(.DEPTH_WORDS(256), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n3), .req(req3), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata3), .done(done3), .err(err3), .stall(stall3)
  );

  task automatic run_txn(input bit sel3, input bit w, input logic [1:0] sz, input bit sx,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input bit exp_err, input int exp_lat,
                         input bit scramble, input bit hold, input string name);
    exp_t e;
    int   n;
    bit   got;
    int   extra;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.lat   = exp_lat;
    sb_q.push_back(e);
    @(negedge clk);
    we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    if (sel3) req3 = 1'b1; else req1 = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if ((sel3 ? done3 : done1) === 1'b1) begin
        got = 1'b1;
      end else begin
        checks++;
        if ((sel3 ? stall3 : stall1) !== 1'b1) begin
          errors++;
          $display("FAIL %s stall: got %b want 1 at cycle %0d", name, sel3 ? stall3 : stall1, n);
        end
      end
      if (scramble && n == 1) begin
        addr = $urandom; wdata = $urandom; size = 2'($urandom); sign_ext = ~sx; we = ~w;
      end
    end
    e = sb_q.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no done within 20 cycles, want latency %0d", name, e.lat);
    end else begin
      $display("txn %-10s addr=%08h rdata=%08h err=%b lat=%0d", name, a,
               sel3 ? rdata3 : rdata1, sel3 ? err3 : err1, n);
      if ((sel3 ? rdata3 : rdata1) !== e.rdata) begin
        errors++;
        $display("FAIL %s rdata: got %08h want %08h", name, sel3 ? rdata3 : rdata1, e.rdata);
      end
      checks++;
      if ((sel3 ? err3 : err1) !== e.err) begin
        errors++;
        $display("FAIL %s err: got %b want %b", name, sel3 ? err3 : err1, e.err);
      end
      checks++;
      if (n != e.lat) begin
        errors++;
        $display("FAIL %s latency: got %0d want %0d", name, n, e.lat);
      end
      checks++;
      if ((sel3 ? stall3 : stall1) !== 1'b0) begin
        errors++;
        $display("FAIL %s stall at done: got %b want 0", name, sel3 ? stall3 : stall1);
      end
    end
    if (hold) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    req1 = 1'b0;
    req3 = 1'b0;
    if (hold) begin
      extra = 0;
      repeat (6) begin
        @(posedge clk);
        #1;
        if ((sel3 ? done3 : done1) === 1'b1) extra++;
      end
      checks++;
      if (extra != 0) begin
        errors++;
        $display("FAIL %s extra done pulses: got %0d want 0", name, extra);
      end
    end
  endtask

  task automatic test_reset();
    req1 = 1'b0; req3 = 1'b0; we = 1'b0; size = 2'b10; sign_ext = 1'b0;
    addr = '0; wdata = '0;
    rst_n1 = 1'b0; rst_n3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({done1, err1, stall1, rdata1} !== 35'd0) begin
      errors++;
      $display("FAIL reset dut1: done=%b err=%b stall=%b rdata=%08h want all 0", done1, err1, stall1, rdata1);
    end
    checks++;
    if ({done3, err3, stall3, rdata3} !== 35'd0) begin
      errors++;
      $display("FAIL reset dut3: done=%b err=%b stall=%b rdata=%08h want all 0", done3, err3, stall3, rdata3);
    end
    @(negedge clk);
    rst_n1 = 1'b1; rst_n3 = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (done1 !== 1'b0 || done3 !== 1'b0) begin
      errors++;
      $display("FAIL idle after reset: done1=%b done3=%b want 0", done1, done3);
    end
  endtask

  task automatic test_word();
    run_txn(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 3, 0, 0, "sw_10");
    run_txn(0, 0, 2'b10, 1, 32'h10, 32'h0,        32'hDEADBEEF, 0, 3, 0, 0, "lw_10");
  endtask

  task automatic test_subword_load();
    run_txn(0, 0, 2'b00, 1, 32'h13, 32'h0, 32'hFFFFFFDE, 0, 3, 0, 0, "lb_13");
    run_txn(0, 0, 2'b00, 0, 32'h13, 32'h0, 32'h000000DE, 0, 3, 0, 0, "lbu_13");
    run_txn(0, 0, 2'b01, 1, 32'h10, 32'h0, 32'hFFFFBEEF, 0, 3, 0, 0, "lh_10");
    run_txn(0, 0, 2'b01, 0, 32'h12, 32'h0, 32'h0000DEAD, 0, 3, 0, 0, "lhu_12");
    run_txn(0, 0, 2'b00, 0, 32'h11, 32'h0, 32'h000000BE, 0, 3, 0, 0, "lbu_11");
  endtask

  task automatic test_subword_store();
    run_txn(0, 1, 2'b00, 0, 32'h11, 32'h123456AA, 32'h0,        0, 3, 1, 0, "sb_11");
    run_txn(0, 0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADAAEF, 0, 3, 0, 0, "lw_10b");
    run_txn(0, 1, 2'b01, 0, 32'h12, 32'hFFFF5A5A, 32'h0,        0, 3, 0, 0, "sh_12");
    run_txn(0, 0, 2'b10, 0, 32'h10, 32'h0,        32'h5A5AAAEF, 0, 3, 0, 0, "lw_10c");
    run_txn(0, 0, 2'b01, 1, 32'h12, 32'h0,        32'h00005A5A, 0, 3, 0, 0, "lh_12");
    run_txn(0, 0, 2'b00, 1, 32'h11, 32'h0,        32'hFFFFFFAA, 0, 3, 0, 0, "lb_11");
  endtask

  task automatic test_misaligned();
    run_txn(0, 1, 2'b10, 0, 32'h00, 32'h11223344, 32'h0,        0, 3, 0, 0, "sw_00");
    run_txn(0, 0, 2'b10, 0, 32'h00, 32'h0,        32'h11223344, 0, 3, 0, 0, "lw_00");
    run_txn(0, 0, 2'b10, 0, 32'h02, 32'h0,        32'h0,        1, 1, 0, 0, "lw_02_mis");
    run_txn(0, 1, 2'b01, 0, 32'h01, 32'h0000FFFF, 32'h0,        1, 1, 0, 0, "sh_01_mis");
    run_txn(0, 1, 2'b11, 0, 32'h03, 32'hFFFFFFFF, 32'h0,        1, 1, 0, 0, "sr_03_mis");
    run_txn(0, 0, 2'b10, 0, 32'h00, 32'h0,        32'h11223344, 0, 3, 0, 0, "lw_00b");
    run_txn(0, 0, 2'b00, 1, 32'h03, 32'h0,        32'h00000011, 0, 3, 0, 0, "lb_03");
  endtask

  task automatic test_reset_mid_wait();
    int stray;
    run_txn(1, 1, 2'b10, 0, 32'h20, 32'hAAAA5555, 32'h0, 0, 5, 0, 0, "sw3_20");
    @(negedge clk);
    we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h20; wdata = 32'h12345678;
    req3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n3 = 1'b0;
    #1;
    checks++;
    if (done3 !== 1'b0 || rdata3 !== 32'h0 || err3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wait: done=%b rdata=%08h err=%b want 0/0/0", done3, rdata3, err3);
    end
    @(negedge clk);
    rst_n3 = 1'b1;
    req3 = 1'b0;
    stray = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (done3 === 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL reset_mid_wait abandoned txn: got %0d done pulses want 0", stray);
    end
    $display("txn reset_mid_wait aborted sw 0x20, stray_done=%0d", stray);
    run_txn(1, 0, 2'b10, 0, 32'h20, 32'h0, 32'hAAAA5555, 0, 5, 0, 0, "lw3_20");
  endtask

  task automatic test_wrap_and_hold();
    run_txn(0, 1, 2'b10, 0, 32'h400, 32'hCAFEF00D, 32'h0,        0, 3, 0, 0, "sw_400");
    run_txn(0, 0, 2'b10, 0, 32'h000, 32'h0,        32'hCAFEF00D, 0, 3, 0, 1, "lw_000_hold");
  endtask

  task automatic test_back_to_back();
    logic [31:0] model [4];
    for (int i = 0; i < 4; i++) begin
      model[i] = $urandom;
      run_txn(0, 1, 2'b10, 0, 32'h40 + 32'(4*i), model[i], 32'h0, 0, 3, 0, 0, "b2b_sw");
    end
    for (int i = 3; i >= 0; i--) begin
      run_txn(0, 0, 2'b10, 0, 32'h40 + 32'(4*i), 32'h0, model[i], 0, 3, 0, 0, "b2b_lw");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word();
    test_subword_load();
    test_subword_store();
    test_misaligned();
    test_reset_mid_wait();
    test_wrap_and_hold();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
- Data-memory stage directly downstream of the execute-stage ALU; the ALU result is the effective address for lw/lh/lb/lbu/lhu/sw/sh/sb.
- Holds DEPTH_WORDS x 32 little-endian RAM and accesses it through a multi-cycle FSM with programmable wait states.
- Drives a stall back to the single-cycle core so PC and register-file writes freeze until the access completes.
- Flags misaligned accesses instead of performing them.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, >= 2. AW = log2(DEPTH_WORDS).
- WAIT_STATES, 1, extra cycles spent in WAIT before the array access; 0..15.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  1  access request; core holds it and the operands stable until done
- we  in  1  1 = store, 0 = load
- size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word)
- sign_ext  in  1  loads only; 1 = sign-extend byte/half, 0 = zero-extend
- addr  in  32  byte address (ALU result)
- wdata  in  32  store data; the low byte/half is used for sb/sh
- rdata  out  32  load result, registered; valid while done = 1
- done  out  1  one-cycle completion pulse
- err  out  1  misaligned flag; valid with done
- stall  out  1  combinational: req & ~done

Behaviour:
- Reset (async assert, sync release): state = IDLE; rdata = 0, done = 0, err = 0, wait counter = 0. RAM contents are not reset.
- States are IDLE, WAIT, ACCESS and RESP. done = (state == RESP), as a Moore output.
- IDLE, req = 1 at edge E0:
  - Latch addr, we, size, sign_ext, wdata.
  - Misaligned means half with addr[0] = 1, or word with addr[1:0] != 00. If misaligned: go to RESP, err = 1, rdata = 0, no RAM write.
  - Else, if WAIT_STATES = 0: go to ACCESS.
  - Else: go to WAIT with counter = WAIT_STATES.
- WAIT: decrement the counter each edge. At the edge where counter == 1, go to ACCESS.
- ACCESS, one edge, always followed by RESP with err = 0:
  - Word index = latched addr[AW+1:2]. Upper address bits are ignored, so the address wraps modulo 4*DEPTH_WORDS.
  - Store: byte-enable write.
    - sb writes lane addr[1:0] with wdata[7:0].
    - sh writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
    - sw writes all four lanes.
    - Store sets rdata = 0.
  - Load: select the lane(s) the same way, extend per sign_ext, and register the result into rdata. Word loads ignore sign_ext.
- RESP: done = 1 for exactly one cycle, then unconditionally IDLE. A req still high at that edge is not a new request; the next request is sampled in IDLE.
- Latency from E0 to done = 1:
  - aligned: WAIT_STATES + 2 cycles;
  - misaligned: 1 cycle.
- Inputs change or req drops mid-transaction: ignored, because latched copies are used and the transaction completes.
- rst_n asserted in any state: immediate return to IDLE.
  - A store not yet in ACCESS is never committed.
  - A store whose ACCESS edge already occurred stays written.
- rdata holds its value after RESP until the next transaction's ACCESS or RESP update.

Decomposition:
- Shared package (mips_pkg) holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state encoding typedef dmem_state_t {IDLE, WAIT, ACCESS, RESP};
  - the width constant 32.
- Sub-module dmem_ram: DEPTH_WORDS x 32 synchronous-write array with 4-bit byte-enable, registered read, no reset. The FSM, alignment check and lane/extend logic stay in data_mem_unit.

Test Plan:
1. WAIT_STATES = 1. sw addr 0x10, wdata 0xDEADBEEF, then lw addr 0x10 -> each done arrives 3 cycles after its req edge; rdata = 0xDEADBEEF; err = 0; stall high until the done cycle.
2. After test 1:
   - lb addr 0x13, sign_ext = 1 -> 0xFFFFFFDE.
   - lbu addr 0x13 -> 0x000000DE.
   - lh addr 0x10, sign_ext = 1 -> 0xFFFFBEEF.
   - lhu addr 0x12 -> 0x0000DEAD.
3. sb addr 0x11, wdata 0x000000AA; then lw addr 0x10 -> 0xDEADAABE? No: the expected value is 0xDEADAAEF. Only lane 1 changes.
4. lw addr 0x02 -> done 1 cycle after E0, err = 1, rdata = 0. sh addr 0x01 -> err = 1, and a following lw 0x00 returns the prior contents unchanged.
5. WAIT_STATES = 3. sw addr 0x20, wdata 0x12345678; pulse rst_n low during WAIT -> state IDLE, done = 0; a later lw 0x20 returns the old value, not 0x12345678.
6. DEPTH_WORDS = 256. sw addr 0x400 (wraps to word 0), wdata 0xCAFEF00D; lw addr 0x000 -> 0xCAFEF00D. Holding req high across RESP yields exactly one done per request.
